// File: rtl/splitter_pkg.sv
// Shared definitions for the word splitter family: FSM encoding, default widths
// and the lane-count saturation rule.
package splitter_pkg;

    localparam int unsigned DEFAULT_WORD_W = 32;
    localparam int unsigned DEFAULT_LANE_W = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    // A requested count of 0 or above the lane total means "the whole word".
    function automatic int unsigned sat_lanes(input int unsigned lanes,
                                              input int unsigned num_lanes);
        if (lanes == 0 || lanes > num_lanes) begin
            return num_lanes;
        end
        return lanes;
    endfunction

endpackage

// File: rtl/lane_mux.sv
// Combinational selector: returns lane i_idx of a word, lane 0 being the
// least-significant LANE_W bits.
module lane_mux #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LANE_W = 8,
    localparam int unsigned NUM_LANES = WORD_W / LANE_W,
    localparam int unsigned IDX_W = $clog2(NUM_LANES + 1)
) (
    input  logic [WORD_W-1:0] i_word,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [LANE_W-1:0] o_lane
);

    always_comb begin
        o_lane = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            if (i_idx == IDX_W'(i)) begin
                o_lane = i_word[i*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/word_lane_serializer.sv
// Splits a WORD_W-bit word into LANE_W-bit lanes emitted one per cycle, with
// per-word lane order and lane count, over valid/ready on both sides.
module word_lane_serializer
    import splitter_pkg::*;
#(
    parameter int unsigned WORD_W = DEFAULT_WORD_W,
    parameter int unsigned LANE_W = DEFAULT_LANE_W,
    localparam int unsigned NUM_LANES = WORD_W / LANE_W,
    localparam int unsigned CNT_W = $clog2(NUM_LANES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_msb_first,
    input  logic [CNT_W-1:0]  in_lanes,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_idx,
    output logic              out_last
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_LANES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    generate
        if ((WORD_W % LANE_W) != 0 || NUM_LANES < 2) begin : g_bad_params
            $error("word_lane_serializer: WORD_W must be a multiple of LANE_W with >= 2 lanes");
        end
    endgenerate

    logic [0:0]        r_state;
    logic [WORD_W-1:0] r_word;
    logic              r_msb;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_left;

    logic              w_in_fire;
    logic              w_out_fire;
    logic [CNT_W-1:0]  w_k;

    assign out_valid = (r_state == ST_EMIT);
    assign out_last  = out_valid && (r_left == ONE);
    assign out_idx   = r_idx;

    // Accepting during the final lane's transfer keeps the output stream gap-free.
    assign in_ready   = (r_state == ST_IDLE) || (out_valid && out_ready && out_last);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_k        = CNT_W'(sat_lanes(32'(in_lanes), NUM_LANES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_msb   <= 1'b0;
            r_idx   <= '0;
            r_left  <= '0;
        end else if (w_in_fire) begin
            r_state <= ST_EMIT;
            r_word  <= in_data;
            r_msb   <= in_msb_first;
            r_left  <= w_k;
            r_idx   <= in_msb_first ? LAST_IDX : '0;
        end else if (w_out_fire) begin
            if (out_last) begin
                r_state <= ST_IDLE;
            end else begin
                r_left <= r_left - ONE;
                r_idx  <= r_msb ? (r_idx - ONE) : (r_idx + ONE);
            end
        end
    end

    lane_mux #(
        .WORD_W(WORD_W),
        .LANE_W(LANE_W)
    ) u_lane_mux (
        .i_word(r_word),
        .i_idx (r_idx),
        .o_lane(out_data)
    );

endmodule

// File: tb/tb_word_lane_serializer.sv
// Bench for word_lane_serializer: directed vector table, hand-written corner
// sequences and randomized traffic against a lane-queue reference model.
module tb_word_lane_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_msb_first = 1'b0;
    logic [2:0]  in_lanes = '0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_out_last;
    logic [7:0]  a_out_data;
    logic [2:0]  a_out_idx;
    logic        b_in_ready, b_out_valid, b_out_last;
    logic [3:0]  b_out_data;
    logic [2:0]  b_out_idx;

    logic        cur_ready, cur_valid, cur_last;
    logic [31:0] cur_data;
    logic [2:0]  cur_idx;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    word_lane_serializer #(.WORD_W(32), .LANE_W(8)) u_dut32 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid && !sel),
        .in_ready    (a_in_ready),
        .in_data     (in_data),
        .in_msb_first(in_msb_first),
        .in_lanes    (in_lanes),
        .out_valid   (a_out_valid),
        .out_ready   (out_ready),
        .out_data    (a_out_data),
        .out_idx     (a_out_idx),
        .out_last    (a_out_last)
    );

    word_lane_serializer #(.WORD_W(16), .LANE_W(4)) u_dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid && sel),
        .in_ready    (b_in_ready),
        .in_data     (in_data[15:0]),
        .in_msb_first(in_msb_first),
        .in_lanes    (in_lanes),
        .out_valid   (b_out_valid),
        .out_ready   (out_ready),
        .out_data    (b_out_data),
        .out_idx     (b_out_idx),
        .out_last    (b_out_last)
    );

    always_comb begin
        cur_ready = a_in_ready;
        cur_valid = a_out_valid;
        cur_last  = a_out_last;
        cur_data  = {24'd0, a_out_data};
        cur_idx   = a_out_idx;
        if (sel) begin
            cur_ready = b_in_ready;
            cur_valid = b_out_valid;
            cur_last  = b_out_last;
            cur_data  = {28'd0, b_out_data};
            cur_idx   = b_out_idx;
        end
    end

    // Reference model: the lanes still owed to the consumer, in emission order.
    typedef struct {
        logic [31:0] data;
        int          idx;
        bit          last;
    } lane_t;
    lane_t exp_q[$];

    typedef struct {
        bit          iv;
        logic [31:0] d;
        bit          msb;
        logic [2:0]  lanes;
        bit          ordy;
        bit          e_ready;
        bit          e_valid;
        logic [7:0]  e_data;
        logic [2:0]  e_idx;
        bit          e_last;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input bit msb, input int lanes);
        int    n  = 4;
        int    lw = sel ? 4 : 8;
        int    k  = (lanes == 0 || lanes > n) ? n : lanes;
        lane_t e;
        for (int j = 0; j < k; j++) begin
            e.idx  = msb ? (n - 1 - j) : j;
            e.data = (w >> (e.idx * lw)) & ((32'd1 << lw) - 32'd1);
            e.last = (j == k - 1);
            exp_q.push_back(e);
        end
    endtask

    // Called at a falling edge; leaves at the next falling edge.
    task automatic cycle(input bit iv, input logic [31:0] d, input bit msb,
                         input logic [2:0] lanes, input bit ordy, input string tag);
        bit e_valid, e_ready;
        in_valid     = iv;
        in_data      = d;
        in_msb_first = msb;
        in_lanes     = lanes;
        out_ready    = ordy;
        #1;
        e_valid = (exp_q.size() != 0);
        e_ready = (exp_q.size() == 0) || (ordy && exp_q.size() == 1);
        chk({tag, ".in_ready"}, 32'(cur_ready), 32'(e_ready));
        chk({tag, ".out_valid"}, 32'(cur_valid), 32'(e_valid));
        if (e_valid) begin
            chk({tag, ".out_data"}, cur_data, exp_q[0].data);
            chk({tag, ".out_idx"}, 32'(cur_idx), 32'(exp_q[0].idx));
            chk({tag, ".out_last"}, 32'(cur_last), 32'(exp_q[0].last));
        end
        if (e_valid && ordy) void'(exp_q.pop_front());
        if (iv && e_ready) push_word(d, msb, int'(lanes));
        @(negedge clk);
    endtask

    task automatic add(input bit iv, input logic [31:0] d, input bit msb, input logic [2:0] l,
                       input bit ordy, input bit er, input bit ev, input logic [7:0] ed,
                       input logic [2:0] ei, input bit el);
        vec_t v;
        v.iv = iv; v.d = d; v.msb = msb; v.lanes = l; v.ordy = ordy;
        v.e_ready = er; v.e_valid = ev; v.e_data = ed; v.e_idx = ei; v.e_last = el;
        tbl.push_back(v);
    endtask

    initial begin
        // iv, data, msb, lanes, ordy | in_ready, out_valid, data, idx, last
        add(1, 32'h1234_5678, 0, 0, 1,  1, 0, 8'h00, 0, 0);
        add(0, 32'h0,         0, 0, 1,  0, 1, 8'h78, 0, 0);
        add(0, 32'h0,         0, 0, 1,  0, 1, 8'h56, 1, 0);
        add(0, 32'h0,         0, 0, 1,  0, 1, 8'h34, 2, 0);
        add(0, 32'h0,         0, 0, 1,  1, 1, 8'h12, 3, 1);
        add(1, 32'h1234_5678, 1, 2, 1,  1, 0, 8'h00, 0, 0);
        add(0, 32'h0,         0, 0, 1,  0, 1, 8'h12, 3, 0);
        add(0, 32'h0,         0, 0, 1,  1, 1, 8'h34, 2, 1);
        add(1, 32'hCAFE_F00D, 0, 1, 1,  1, 0, 8'h00, 0, 0);
        add(0, 32'h0,         0, 0, 1,  1, 1, 8'h0D, 0, 1);
        add(1, 32'hAABB_CCDD, 1, 7, 1,  1, 0, 8'h00, 0, 0);
        add(0, 32'h0,         0, 0, 1,  0, 1, 8'hAA, 3, 0);
        add(1, 32'hFFFF_FFFF, 0, 1, 0,  0, 1, 8'hBB, 2, 0);
        add(0, 32'h0,         0, 0, 1,  0, 1, 8'hBB, 2, 0);
        add(0, 32'h0,         0, 0, 1,  0, 1, 8'hCC, 1, 0);
        add(0, 32'h0,         0, 0, 0,  0, 1, 8'hDD, 0, 1);
        add(0, 32'h0,         0, 0, 1,  1, 1, 8'hDD, 0, 1);
        add(0, 32'h0,         0, 0, 1,  1, 0, 8'h00, 0, 0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst32.in_ready", 32'(a_in_ready), 32'd1);
        chk("rst32.out_valid", 32'(a_out_valid), 32'd0);
        chk("rst32.out_data", 32'(a_out_data), 32'd0);
        chk("rst32.out_idx", 32'(a_out_idx), 32'd0);
        chk("rst32.out_last", 32'(a_out_last), 32'd0);
        chk("rst16.in_ready", 32'(b_in_ready), 32'd1);
        chk("rst16.out_valid", 32'(b_out_valid), 32'd0);
        @(negedge clk);

        foreach (tbl[i]) begin
            in_valid     = tbl[i].iv;
            in_data      = tbl[i].d;
            in_msb_first = tbl[i].msb;
            in_lanes     = tbl[i].lanes;
            out_ready    = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d.in_ready", i), 32'(a_in_ready), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d.out_valid", i), 32'(a_out_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d.out_data", i), 32'(a_out_data), 32'(tbl[i].e_data));
                chk($sformatf("tbl%0d.out_idx", i), 32'(a_out_idx), 32'(tbl[i].e_idx));
                chk($sformatf("tbl%0d.out_last", i), 32'(a_out_last), 32'(tbl[i].e_last));
            end
            @(negedge clk);
        end

        // Backpressure with out_ready pattern 1,0,0,1 repeating.
        cycle(1, 32'hDEAD_BEEF, 0, 0, 1, "bp");
        for (int i = 0; i < 10; i++) begin
            cycle(0, 32'h0, 0, 0, (i % 4 == 0) || (i % 4 == 3), "bp");
        end

        // Back-to-back words with in_valid held high.
        cycle(1, 32'hA1B2_C3D4, 0, 0, 1, "b2b");
        repeat (4) cycle(1, 32'h0102_0304, 0, 0, 1, "b2b");
        repeat (5) cycle(0, 32'h0, 0, 0, 1, "b2b");

        // Asynchronous reset in the middle of a word.
        cycle(1, 32'h1234_5678, 0, 0, 1, "rstmid");
        repeat (2) cycle(0, 32'h0, 0, 0, 1, "rstmid");
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid.async_out_valid", 32'(a_out_valid), 32'd0);
        chk("rstmid.async_out_data", 32'(a_out_data), 32'd0);
        chk("rstmid.async_out_idx", 32'(a_out_idx), 32'd0);
        chk("rstmid.async_out_last", 32'(a_out_last), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cycle(0, 32'h0, 0, 0, 1, "rstpost");

        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            if (sel) begin
                cycle(1, 32'h0000_ABCD, 1, 0, 1, "w16");
                repeat (5) cycle(0, 32'h0, 0, 0, 1, "w16");
                cycle(1, 32'h0000_ABCD, 0, 5, 1, "w16sat");
                repeat (5) cycle(0, 32'h0, 0, 0, 1, "w16sat");
            end
            for (int i = 0; i < 1500; i++) begin
                cycle($urandom_range(99) < 60, $urandom, 1'($urandom_range(1)),
                      3'($urandom_range(7)), $urandom_range(99) < 70, "rnd");
            end
            repeat (8) cycle(0, 32'h0, 0, 0, 1, "drain");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
